// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_if
// Description : Host command/response port plus APB bus signals for apb_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Host command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;

    // Host response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    // APB bus
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     padd;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslevrr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output psel, penable, pwrite, padd, pwdata, pstrb,
        input  prdata, pready, pslevrr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  psel, penable, pwrite, padd, pwdata, pstrb,
        output prdata, pready, pslevrr
    );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB initiator; host command in, APB
//               SETUP/ACCESS transfer out, read data/error back on a
//               valid/ready response. Optional macro APB_TIMEOUT_EN adds an
//               ACCESS-phase wait-state abort after TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic     pclk,
    input  wire logic     rst,
    apb_master_if.master  bus
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0]          r_state;
    logic                r_cmd_ready;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_padd;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                w_cmd_fire;

    assign w_cmd_fire = bus.cmd_valid && r_cmd_ready;

`ifdef APB_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                             $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic [c_CNT_W:0]    w_wait_next;
    logic                w_timeout;

    // Abort on the wait cycle that would bring the count up to the limit.
    assign w_wait_next = {1'b0, r_wait_cnt} + {{c_CNT_W{1'b0}}, 1'b1};
    assign w_timeout   = (w_wait_next >= {1'b0, c_LIMIT});
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_padd      <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_pwrite    <= bus.cmd_write;
                        r_padd      <= bus.cmd_addr;
                        r_pwdata    <= bus.cmd_wdata;
                        // Reads never carry strobes onto the bus.
                        r_pstrb     <= bus.cmd_write ? bus.cmd_strb : '0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= c_ST_SETUP;
                    end
                end

                c_ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= c_ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end

                c_ST_ACCESS: begin
                    if (bus.pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
                        r_rsp_err   <= bus.pslevrr;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= c_ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.padd      = r_padd;
    assign bus.pwdata    = r_pwdata;
    assign bus.pstrb     = r_pstrb;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
